// File: rtl/board_win_checker.sv
// Sequential 4-in-a-row scanner over a snapshot of the 6x7 board, one (anchor, dir) window per cycle.
// Optional board-consistency check (floating pieces, owner-without-piece) built only with BOARD_CHECK_EN.
module board_win_checker #(
   parameter int ROWS    = 6,
   parameter int COLS    = 7,
   parameter int WIN_LEN = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [ROWS*COLS-1:0] in_gameboard,
   input  logic [ROWS*COLS-1:0] in_players_cells,
   output logic                 busy,
   output logic                 done,
   output logic [1:0]           winner,
   output logic                 draw,
   output logic [ROWS*COLS-1:0] win_mask,
   output logic                 illegal
);
   localparam int CELLS = ROWS * COLS;
   localparam int IW    = $clog2(CELLS);
   localparam int RW    = $clog2(ROWS);
   localparam int CW    = $clog2(COLS);

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
   state_t state, next_state;

   logic [CELLS-1:0] board_snap, owner_snap;
   logic [RW-1:0]    row;
   logic [CW-1:0]    col;
   logic [1:0]       dir;
   logic             last_pair, hit, hit_owner;
   logic [CELLS-1:0] hit_mask;
   logic             in_bounds, all_occ, all_zero, all_one;
   int               r_k, c_k, dr, dc;
   logic [IW-1:0]    idx;

   assign last_pair = (dir == 2'd3) && (col == CW'(COLS - 1)) && (row == RW'(ROWS - 1));

   // Window under test: cells anchor + k*(dr,dc); any cell off the board kills the match (no row wrap).
   always_comb begin
      hit_mask  = '0;
      in_bounds = 1'b1;
      all_occ   = 1'b1;
      all_zero  = 1'b1;
      all_one   = 1'b1;
      r_k       = 0;
      c_k       = 0;
      idx       = '0;
      dr        = (dir == 2'd0) ? 0 : 1;
      dc        = (dir == 2'd1) ? 0 : ((dir == 2'd3) ? -1 : 1);
      for (int k = 0; k < WIN_LEN; k++) begin
         r_k = int'(row) + k * dr;
         c_k = int'(col) + k * dc;
         if (r_k < 0 || r_k >= ROWS || c_k < 0 || c_k >= COLS) begin
            in_bounds = 1'b0;
         end else begin
            idx           = IW'(r_k * COLS + c_k);
            hit_mask[idx] = 1'b1;
            all_occ       = all_occ & board_snap[idx];
            all_zero      = all_zero & ~owner_snap[idx];
            all_one       = all_one & owner_snap[idx];
         end
      end
      hit       = in_bounds & all_occ & (all_zero | all_one);
      hit_owner = all_one;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start) next_state = SCAN;
         SCAN:    if (hit || last_pair) next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == SCAN);
      done = (state == DONE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         board_snap <= '0;
         owner_snap <= '0;
         row        <= '0;
         col        <= '0;
         dir        <= '0;
         winner     <= 2'b00;
         draw       <= 1'b0;
         win_mask   <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               board_snap <= in_gameboard;
               owner_snap <= in_players_cells;
               row        <= '0;
               col        <= '0;
               dir        <= '0;
               winner     <= 2'b00;
               draw       <= 1'b0;
               win_mask   <= '0;
            end
            SCAN: if (hit) begin
               winner   <= hit_owner ? 2'b10 : 2'b01;
               win_mask <= hit_mask;
            end else if (last_pair) begin
               draw <= &board_snap;
            end else begin
               dir <= dir + 2'd1;
               if (dir == 2'd3) begin
                  if (col == CW'(COLS - 1)) begin
                     col <= '0;
                     row <= row + RW'(1);
                  end else begin
                     col <= col + CW'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

`ifdef BOARD_CHECK_EN
   logic illegal_c;

   // Owner bit on an empty cell, or a piece resting on an empty cell directly below it.
   assign illegal_c = (|(owner_snap & ~board_snap)) |
                      (|(board_snap[CELLS-1:COLS] & ~board_snap[CELLS-COLS-1:0]));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                                  illegal <= 1'b0;
      else if (state == IDLE && start)             illegal <= 1'b0;
      else if (state == SCAN && (hit || last_pair)) illegal <= illegal_c;
   end
`else
   assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_board_win_checker.sv
// Directed bench for board_win_checker: hand-computed boards plus a reference scan for generated boards.
module tb_board_win_checker;
   localparam int ROWS  = 6;
   localparam int COLS  = 7;
   localparam int CELLS = ROWS * COLS;
`ifdef BOARD_CHECK_EN
   localparam logic CHK = 1'b1;
`else
   localparam logic CHK = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             reset;
   logic             start;
   logic [CELLS-1:0] in_gameboard, in_players_cells;
   logic             busy, done, draw, illegal;
   logic [1:0]       winner;
   logic [CELLS-1:0] win_mask;

   int n_checks = 0;
   int n_fail   = 0;

   board_win_checker dut (
      .clk              (clk),
      .reset            (reset),
      .start            (start),
      .in_gameboard     (in_gameboard),
      .in_players_cells (in_players_cells),
      .busy             (busy),
      .done             (done),
      .winner           (winner),
      .draw             (draw),
      .win_mask         (win_mask),
      .illegal          (illegal)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference scan: first (anchor, dir) in pair order whose four cells are all occupied by one owner.
   task automatic model_scan(input logic [CELLS-1:0] brd, input logic [CELLS-1:0] own,
                             output int p, output logic [1:0] w, output logic [CELLS-1:0] m);
      int dr [4] = '{0, 1, 1, 1};
      int dc [4] = '{1, 0, 1, -1};
      p = -1;
      w = 2'b00;
      m = '0;
      for (int a = 0; a < CELLS && p < 0; a++) begin
         for (int d = 0; d < 4 && p < 0; d++) begin
            int ok, o0, rr, cc;
            logic [CELLS-1:0] mm;
            ok = 1;
            mm = '0;
            o0 = own[a];
            for (int k = 0; k < 4; k++) begin
               rr = a / COLS + k * dr[d];
               cc = a % COLS + k * dc[d];
               if (rr < 0 || rr >= ROWS || cc < 0 || cc >= COLS) ok = 0;
               else if (!brd[rr*COLS+cc] || int'(own[rr*COLS+cc]) != o0) ok = 0;
               else mm[rr*COLS+cc] = 1'b1;
            end
            if (ok == 1) begin
               p = a * 4 + d;
               w = (o0 == 1) ? 2'b10 : 2'b01;
               m = mm;
            end
         end
      end
   endtask

   // Caller sits #1 after an edge with the DUT in IDLE; start is sampled at the next edge (E0).
   task automatic run_scan(input string tag, input logic [CELLS-1:0] brd, input logic [CELLS-1:0] own,
                           input int exp_lat, input logic [1:0] exp_w, input logic exp_d,
                           input logic [CELLS-1:0] exp_m, input logic exp_i);
      int lat, busy_cnt;
      in_gameboard     = brd;
      in_players_cells = own;
      start            = 1'b1;
      @(posedge clk); #1;
      start            = 1'b0;
      in_gameboard     = ~brd;
      in_players_cells = ~own;
      lat      = 0;
      busy_cnt = 0;
      while (!done && lat < 300) begin
         if (busy) busy_cnt++;
         @(posedge clk); #1;
         lat++;
      end
      check({tag, ".latency"}, 64'(lat), 64'(exp_lat));
      check({tag, ".busy_cycles"}, 64'(busy_cnt), 64'(exp_lat));
      check({tag, ".busy_at_done"}, 64'(busy), 64'(0));
      check({tag, ".winner"}, 64'(winner), 64'(exp_w));
      check({tag, ".draw"}, 64'(draw), 64'(exp_d));
      check({tag, ".win_mask"}, 64'(win_mask), 64'(exp_m));
      check({tag, ".illegal"}, 64'(illegal), 64'(exp_i));
      @(posedge clk); #1;
      check({tag, ".done_pulse"}, 64'(done), 64'(0));
      check({tag, ".winner_hold"}, 64'(winner), 64'(exp_w));
   endtask

   initial begin
      logic [CELLS-1:0] brd, own, m;
      logic [1:0]       w;
      int               p, saw_done;

      reset            = 1'b0;
      start            = 1'b0;
      in_gameboard     = '0;
      in_players_cells = '0;
      #1;
      check("reset.busy", 64'(busy), 64'(0));
      check("reset.done", 64'(done), 64'(0));
      check("reset.winner", 64'(winner), 64'(0));
      check("reset.draw", 64'(draw), 64'(0));
      check("reset.mask", 64'(win_mask), 64'(0));
      check("reset.illegal", 64'(illegal), 64'(0));
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;

      run_scan("empty", '0, '0, 168, 2'b00, 1'b0, '0, 1'b0);
      run_scan("row0_p1", 42'h00F, '0, 1, 2'b01, 1'b0, 42'h00F, 1'b0);
      brd = '0;
      brd[6] = 1'b1; brd[13] = 1'b1; brd[20] = 1'b1; brd[27] = 1'b1;
      run_scan("col6_p2", brd, brd, 26, 2'b10, 1'b0, brd, 1'b0);
      brd = '0;
      brd[0] = 1'b1; brd[8] = 1'b1; brd[16] = 1'b1; brd[24] = 1'b1;
      run_scan("diag_p2", brd, brd, 3, 2'b10, 1'b0, brd, CHK);
      brd = '0;
      brd[3] = 1'b1; brd[9] = 1'b1; brd[15] = 1'b1; brd[21] = 1'b1;
      run_scan("antidiag_p1", brd, '0, 16, 2'b01, 1'b0, brd, CHK);

      // P1 vertical in col 0 (pair 1) precedes the P2 row starting at col 1 (pair 4).
      brd = '0; own = '0; m = '0;
      brd[0] = 1'b1; brd[7] = 1'b1; brd[14] = 1'b1; brd[21] = 1'b1;
      m = brd;
      for (int c = 1; c <= 4; c++) begin
         brd[c] = 1'b1;
         own[c] = 1'b1;
      end
      run_scan("first_match", brd, own, 2, 2'b01, 1'b0, m, 1'b0);

      brd = '0;
      brd[5] = 1'b1; brd[6] = 1'b1; brd[7] = 1'b1; brd[8] = 1'b1;
      model_scan(brd, '0, p, w, m);
      run_scan("no_wrap", brd, '0, (p < 0) ? 168 : p + 1, w, 1'b0, m, CHK);

      // Full board, owner = (row/2 + col) mod 2 leaves no run of four in any direction.
      brd = '1; own = '0;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            own[r*COLS+c] = 1'(((r / 2) + c) % 2);
      model_scan(brd, own, p, w, m);
      run_scan("full_draw", brd, own, (p < 0) ? 168 : p + 1, w, (p < 0), m, 1'b0);

      brd = '0; brd[7] = 1'b1;
      run_scan("floating", brd, '0, 168, 2'b00, 1'b0, '0, CHK);
      own = '0; own[5] = 1'b1;
      run_scan("owner_no_piece", '0, own, 168, 2'b00, 1'b0, '0, CHK);

      // Extra start mid-scan is ignored, then reset at E0+50 aborts the scan.
      in_gameboard = '0; in_players_cells = '0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      saw_done = 0;
      repeat (4) begin
         @(posedge clk); #1;
         if (done) saw_done = 1;
      end
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("restart.busy", 64'(busy), 64'(1));
      repeat (45) begin
         @(posedge clk); #1;
         if (done) saw_done = 1;
      end
      check("abort.no_early_done", 64'(saw_done), 64'(0));
      #2;
      reset = 1'b0;
      #1;
      check("abort.busy", 64'(busy), 64'(0));
      check("abort.done", 64'(done), 64'(0));
      check("abort.winner", 64'(winner), 64'(0));
      check("abort.mask", 64'(win_mask), 64'(0));
      check("abort.draw_illegal", 64'({draw, illegal}), 64'(0));
      repeat (3) begin
         @(posedge clk); #1;
         if (done) saw_done = 1;
      end
      check("abort.no_done", 64'(saw_done), 64'(0));
      reset = 1'b1;
      @(posedge clk); #1;
      run_scan("after_reset", 42'h00F, '0, 1, 2'b01, 1'b0, 42'h00F, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
